spi_cmd_regs: RTL and testbench

Parametrised SPI command register block for the core.
- Decodes completed SPI messages from the ESP32 link (spi_cmd, 64-bit spi_rxdata, spi_msg_end strobe) into core control outputs: reset request, CPU select, turbo, video mode, keyboard matrix, N hand controllers.
- Adds an internal keyboard FIFO loaded by multi-byte burst messages and drained by the core.
- Adds a status readback command on spi_txdata.

---
 rtl/spi_cmd_regs_pkg.sv | 16 +
 rtl/spi_cmd_regs_if.sv | 10 +
 rtl/spi_cmd_regs_kbbuf_fifo.sv | 42 ++++
 rtl/spi_cmd_regs.sv | 85 ++++++++
 tb/tb_spi_cmd_regs.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cmd_regs_pkg.sv
// spiregs_pkg: command codes, status word layout and burst state for spi_cmd_regs.
package spiregs_pkg;
  localparam logic [7:0] CMD_RESET           = 8'h01;
  localparam logic [7:0] CMD_FORCE_TURBO     = 8'h02;
  localparam logic [7:0] CMD_SET_KEYB_MATRIX = 8'h10;
  localparam logic [7:0] CMD_SET_HCTRL       = 8'h11;
  localparam logic [7:0] CMD_WRITE_KBBUF     = 8'h12;
  localparam logic [7:0] CMD_GET_STATUS      = 8'h13;
  localparam logic [7:0] CMD_FLUSH_KBBUF     = 8'h14;
  localparam logic [7:0] CMD_SET_VIDMODE     = 8'h40;
  localparam int ST_COUNT_LSB = 56;
  localparam int ST_OVF       = 55;
  localparam int ST_BUSY      = 54;
  localparam int ST_DEPTH_LSB = 40;
  typedef enum logic {IDLE, BURST} burst_t;
endpackage

// File: rtl/spi_cmd_regs_if.sv
// spi_cmd_regs_if: completed-message side of the ESP32 SPI link.
interface spi_cmd_regs_if;
  logic        spi_msg_end;
  logic [7:0]  spi_cmd;
  logic [63:0] spi_rxdata;
  logic [63:0] spi_txdata;
  logic        spi_txdata_valid;
  modport master (output spi_msg_end, spi_cmd, spi_rxdata, input spi_txdata, spi_txdata_valid);
  modport slave (input spi_msg_end, spi_cmd, spi_rxdata, output spi_txdata, spi_txdata_valid);
endinterface

// File: rtl/spi_cmd_regs_kbbuf_fifo.sv
// kbbuf_fifo: byte FIFO with first-word fall-through read, flush and async reset.
module kbbuf_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign empty = count == '0;
  assign full  = count[AW];
  assign rd    = pop && !empty;
  // a pop frees the slot, so a full FIFO still accepts a same-cycle push
  assign wr    = push && (!full || rd);
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
endmodule

// File: rtl/spi_cmd_regs.sv
// spi_cmd_regs: decodes completed ESP32 SPI messages into core control registers,
// a burst-loaded keyboard FIFO and a status readback word.
module spi_cmd_regs
  import spiregs_pkg::*;
#(
  parameter int NUM_HCTRL   = 2,
  parameter int KBBUF_DEPTH = 16,
  parameter int VIDMODE_W   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  spi_cmd_regs_if.slave          spi,
  output logic                   reset_req,
  output logic [63:0]            keys,
  output logic [8*NUM_HCTRL-1:0] hctrl,
  output logic                   use_t80,
  input  logic                   has_z80,
  output logic                   force_turbo,
  output logic [VIDMODE_W-1:0]   video_mode,
  input  logic                   kbbuf_rd,
  output logic [7:0]             kbbuf_rdata,
  output logic                   kbbuf_empty
);
  localparam int CW = $clog2(KBBUF_DEPTH) + 1;
  burst_t state;
  logic [55:0] shreg;
  logic [2:0] left;
  logic [7:0] cmd;
  logic [CW-1:0] count;
  logic me, use_t80_r, ovf, full, busy, flush, drop;
  assign me    = spi.spi_msg_end;
  assign cmd   = spi.spi_cmd;
  assign busy  = state == BURST;
  assign flush = me && cmd == CMD_FLUSH_KBBUF;
  assign drop  = busy && full && !kbbuf_rd;
  assign use_t80 = has_z80 ? use_t80_r : 1'b1;
  assign spi.spi_txdata_valid = cmd == CMD_GET_STATUS;
  always_comb begin
    spi.spi_txdata = '0;
    if (spi.spi_txdata_valid) begin
      spi.spi_txdata[ST_COUNT_LSB +: 8] = 8'(count);
      spi.spi_txdata[ST_OVF]            = ovf;
      spi.spi_txdata[ST_BUSY]           = busy;
      spi.spi_txdata[ST_DEPTH_LSB +: 8] = 8'(KBBUF_DEPTH - 1);
    end
  end
  kbbuf_fifo #(.DEPTH(KBBUF_DEPTH)) fifo (
    .clk(clk), .reset(reset), .push(busy), .pop(kbbuf_rd), .flush(flush),
    .wdata(shreg[55:48]), .rdata(kbbuf_rdata), .full(full), .empty(kbbuf_empty), .count(count)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      reset_req   <= 1'b0;
      use_t80_r   <= 1'b0;
      force_turbo <= 1'b0;
      video_mode  <= '0;
      keys        <= '1;
      hctrl       <= '1;
      ovf         <= 1'b0;
      state       <= IDLE;
      shreg       <= '0;
      left        <= '0;
    end else begin
      reset_req <= me && cmd == CMD_RESET;
      if (me && cmd == CMD_RESET) use_t80_r <= spi.spi_rxdata[56];
      if (me && cmd == CMD_FORCE_TURBO) force_turbo <= spi.spi_rxdata[56];
      if (me && cmd == CMD_SET_KEYB_MATRIX) keys <= spi.spi_rxdata;
      if (me && cmd == CMD_SET_HCTRL) hctrl <= spi.spi_rxdata[63 -: 8*NUM_HCTRL];
      if (me && cmd == CMD_SET_VIDMODE) video_mode <= spi.spi_rxdata[56 +: VIDMODE_W];
      // a set in the same cycle as a status read must survive the read-clear
      ovf <= flush ? 1'b0 :
             (drop || (me && cmd == CMD_WRITE_KBBUF && busy)) ? 1'b1 :
             (me && cmd == CMD_GET_STATUS) ? 1'b0 : ovf;
      if (flush) state <= IDLE;
      else if (busy) begin
        shreg <= shreg << 8;
        left  <= left - 1'b1;
        if (left == 3'd1) state <= IDLE;
      end else if (me && cmd == CMD_WRITE_KBBUF && spi.spi_rxdata[58:56] != 3'd0) begin
        shreg <= spi.spi_rxdata[55:0];
        left  <= spi.spi_rxdata[58:56];
        state <= BURST;
      end
    end
endmodule

// File: tb/tb_spi_cmd_regs.sv
// tb_spi_cmd_regs: randomized scoreboard bench with a queue-based reference model.
module tb_spi_cmd_regs;
  localparam int NH = 2, DEPTH = 16, VW = 1;
  logic clk = 0, reset = 1, has_z80 = 0, kbbuf_rd = 0;
  logic reset_req, use_t80, force_turbo, kbbuf_empty;
  logic [63:0] keys;
  logic [8*NH-1:0] hctrl;
  logic [VW-1:0] video_mode;
  logic [7:0] kbbuf_rdata;
  spi_cmd_regs_if spi();
  spi_cmd_regs #(.NUM_HCTRL(NH), .KBBUF_DEPTH(DEPTH), .VIDMODE_W(VW)) dut (
    .clk(clk), .reset(reset), .spi(spi), .reset_req(reset_req), .keys(keys), .hctrl(hctrl),
    .use_t80(use_t80), .has_z80(has_z80), .force_turbo(force_turbo), .video_mode(video_mode),
    .kbbuf_rd(kbbuf_rd), .kbbuf_rdata(kbbuf_rdata), .kbbuf_empty(kbbuf_empty)
  );
  always #5 clk = ~clk;

  byte unsigned mq[$], pend[$];
  bit ovf, m_turbo, m_t80, m_rr;
  logic [63:0] m_keys;
  logic [8*NH-1:0] m_hctrl;
  logic [VW-1:0] m_vm;
  logic [63:0] exp_st[$];
  logic [7:0] exp_rd[$];
  int checks = 0, failures = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic void mreset();
    mq.delete(); pend.delete();
    ovf = 0; m_turbo = 0; m_t80 = 0; m_rr = 0;
    m_keys = '1; m_hctrl = '1; m_vm = '0;
  endfunction

  function automatic logic [63:0] exp_status();
    return {8'(mq.size()), ovf, pend.size() > 0, 6'b0, 8'(DEPTH - 1), 40'b0};
  endfunction

  function automatic logic [63:0] mk(int n, int base);
    logic [63:0] d = '0;
    d[58:56] = n[2:0];
    for (int i = 0; i < 7; i++) d[55-8*i -: 8] = 8'(base + i);
    return d;
  endfunction

  // reference model: a byte queue for the FIFO, a pending-byte queue for the burst
  always @(posedge clk) begin : model
    bit me, busy, rde, set, fl;
    byte unsigned b;
    logic [7:0] c;
    logic [63:0] rx;
    if (reset) mreset();
    else begin
      me = spi.spi_msg_end; c = spi.spi_cmd; rx = spi.spi_rxdata;
      fl = me && c == 8'h14;
      busy = pend.size() > 0;
      rde = kbbuf_rd && mq.size() > 0;
      set = 0;
      m_rr = me && c == 8'h01;
      if (fl) begin
        mq.delete(); pend.delete(); ovf = 0;
      end else begin
        if (rde) void'(mq.pop_front());
        if (busy) begin
          b = pend.pop_front();
          if (mq.size() < DEPTH) mq.push_back(b); else set = 1;
        end
        if (me && c == 8'h12) begin
          if (busy) set = 1;
          else for (int i = 0; i < int'(rx[58:56]); i++) pend.push_back(rx[55-8*i -: 8]);
        end
        if (me && c == 8'h13) ovf = 0;
        if (set) ovf = 1;
      end
      if (me && c == 8'h01) m_t80 = rx[56];
      if (me && c == 8'h02) m_turbo = rx[56];
      if (me && c == 8'h10) m_keys = rx;
      if (me && c == 8'h11) m_hctrl = rx[63 -: 8*NH];
      if (me && c == 8'h40) m_vm = rx[56 +: VW];
    end
  end

  always @(negedge clk) if (!reset) begin
    chk("reset_req", reset_req, m_rr);
    chk("keys", keys, m_keys);
    chk("hctrl", hctrl, m_hctrl);
    chk("force_turbo", force_turbo, m_turbo);
    chk("video_mode", video_mode, m_vm);
    chk("use_t80", use_t80, has_z80 ? m_t80 : 1'b1);
    chk("kbbuf_empty", kbbuf_empty, mq.size() == 0);
    if (spi.spi_txdata_valid) begin
      if (exp_st.size() == 0) chk("txvalid_unexpected", spi.spi_txdata_valid, 1'b0);
      else chk("status", spi.spi_txdata, exp_st.pop_front());
    end else chk("txdata_idle", spi.spi_txdata, 64'h0);
    if (kbbuf_rd && !kbbuf_empty) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", kbbuf_empty, 1'b1);
      else chk("rd_data", kbbuf_rdata, exp_rd.pop_front());
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic idle(int n); repeat (n) cyc(); endtask
  task automatic send(logic [7:0] c, logic [63:0] d);
    spi.spi_msg_end = 1; spi.spi_cmd = c; spi.spi_rxdata = d;
    if (c == 8'h13) exp_st.push_back(exp_status());
    cyc();
    spi.spi_msg_end = 0; spi.spi_cmd = 0;
  endtask
  task automatic rd(int n);
    repeat (n) begin
      kbbuf_rd = 1;
      if (mq.size() > 0) exp_rd.push_back(mq[0]);
      cyc();
    end
    kbbuf_rd = 0;
  endtask
  task automatic peek(string nm, logic [63:0] want);
    spi.spi_cmd = 8'h13;
    exp_st.push_back(exp_status());
    #1 chk(nm, spi.spi_txdata, want);
    cyc();
    spi.spi_cmd = 0;
  endtask
  task automatic fill16();
    send(8'h12, mk(7, 8'h60)); idle(7);
    send(8'h12, mk(7, 8'h70)); idle(7);
    send(8'h12, mk(2, 8'h80)); idle(2);
  endtask

  initial begin
    logic [7:0] cmds[13] = '{8'h12, 8'h12, 8'h12, 8'h12, 8'h13, 8'h13, 8'h01,
                             8'h02, 8'h10, 8'h11, 8'h40, 8'h14, 8'h55};
    logic [7:0] c;
    spi.spi_msg_end = 0; spi.spi_cmd = 0; spi.spi_rxdata = 0;
    mreset();
    idle(3);
    reset = 0;
    cyc();
    chk("rst_keys", keys, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_hctrl", hctrl, 16'hFFFF);
    chk("rst_turbo", force_turbo, 1'b0);
    chk("rst_vmode", video_mode, 1'b0);
    chk("rst_empty", kbbuf_empty, 1'b1);
    chk("rst_use_t80_noz80", use_t80, 1'b1);
    has_z80 = 1;
    send(8'h01, 64'h0100_0000_0000_0000);
    chk("reset_req_pulse", reset_req, 1'b1);
    chk("use_t80_set", use_t80, 1'b1);
    cyc();
    chk("reset_req_clear", reset_req, 1'b0);
    send(8'h11, 64'hABCD_0000_0000_0000);
    chk("hctrl_abcd", hctrl, 16'hABCD);
    send(8'h12, 64'h0341_4243_0000_0000);
    chk("burst_not_yet", kbbuf_empty, 1'b1);
    cyc();
    chk("burst_head", kbbuf_rdata, 8'h41);
    idle(2);
    rd(3);
    chk("burst_drained", kbbuf_empty, 1'b1);
    rd(1);
    send(8'h12, mk(0, 8'h10));
    idle(2);
    chk("n0_noop", kbbuf_empty, 1'b1);
    fill16();
    send(8'h12, mk(2, 8'h90)); idle(3);
    peek("status_overflow", 64'h1080_0F00_0000_0000);
    send(8'h13, 64'h0);
    peek("status_cleared", 64'h1000_0F00_0000_0000);
    send(8'h14, 64'h0);
    send(8'h12, mk(7, 8'h20));
    send(8'h12, mk(3, 8'h30));
    idle(8);
    peek("status_ignored_burst", 64'h0780_0F00_0000_0000);
    send(8'h14, 64'h0);
    send(8'h12, mk(7, 8'h40)); idle(2);
    send(8'h14, 64'h0);
    peek("status_flush_midburst", 64'h0000_0F00_0000_0000);
    idle(8);
    chk("flush_stays_empty", kbbuf_empty, 1'b1);
    fill16();
    send(8'h12, mk(2, 8'hA0));
    rd(2);
    peek("status_full_pushpop", 64'h1000_0F00_0000_0000);
    rd(16);
    chk("full_drained", kbbuf_empty, 1'b1);
    repeat (500) begin
      c = cmds[$urandom_range(0, 12)];
      spi.spi_msg_end = $urandom_range(0, 2) == 0;
      spi.spi_cmd = c;
      spi.spi_rxdata = {$urandom, $urandom};
      has_z80 = 1'($urandom);
      kbbuf_rd = $urandom_range(0, 3) == 0;
      if (c == 8'h13) exp_st.push_back(exp_status());
      if (kbbuf_rd && mq.size() > 0) exp_rd.push_back(mq[0]);
      cyc();
    end
    spi.spi_msg_end = 0; spi.spi_cmd = 0; kbbuf_rd = 0;
    idle(10);
    rd(DEPTH + 2);
    send(8'h14, 64'h0);
    send(8'h10, 64'h0123_4567_89AB_CDEF);
    send(8'h02, 64'h0100_0000_0000_0000);
    send(8'h12, mk(7, 8'hC0)); idle(2);
    reset = 1;
    mreset();
    #1;
    chk("async_keys", keys, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("async_turbo", force_turbo, 1'b0);
    chk("async_empty", kbbuf_empty, 1'b1);
    chk("async_hctrl", hctrl, 16'hFFFF);
    idle(2);
    reset = 0;
    cyc();
    peek("status_after_reset", 64'h0000_0F00_0000_0000);
    idle(3);
    chk("exp_status_drained", 64'(exp_st.size()), 64'h0);
    chk("exp_reads_drained", 64'(exp_rd.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
